// File: rtl/str_to_num_pkg.sv
// Shared definitions for the ASCII number-token parsers.
// Parser FSM state encoding and the ASCII code points the parsers match on.
package str_to_num_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        NEG   = 3'd1,
        LEAD0 = 3'd2,
        DEC   = 3'd3,
        HEXF  = 3'd4,
        HEX   = 3'd5,
        SEND  = 3'd6
    } state_t;

    localparam logic [7:0] CH_0     = 8'h30;
    localparam logic [7:0] CH_9     = 8'h39;
    localparam logic [7:0] CH_LA    = 8'h61;
    localparam logic [7:0] CH_LF    = 8'h66;
    localparam logic [7:0] CH_UA    = 8'h41;
    localparam logic [7:0] CH_UF    = 8'h46;
    localparam logic [7:0] CH_LX    = 8'h78;
    localparam logic [7:0] CH_UX    = 8'h58;
    localparam logic [7:0] CH_MINUS = 8'h2D;

endpackage

// File: rtl/ascii_digit_decode.sv
// Classifies one ASCII character as a decimal and/or hex digit and gives its value.
// Purely combinational; there is no handshake, so it cannot apply backpressure.
module ascii_digit_decode
    import str_to_num_pkg::*;
(
    input  logic [7:0] ch,
    output logic       is_dec,
    output logic       is_hex,
    output logic [3:0] nibble
);

    logic is_lo;
    logic is_up;

    always_comb begin
        is_dec = (ch >= CH_0) && (ch <= CH_9);
        is_lo  = (ch >= CH_LA) && (ch <= CH_LF);
        is_up  = (ch >= CH_UA) && (ch <= CH_UF);
        is_hex = is_dec || is_lo || is_up;
        nibble = 4'd0;
        // Letters a-f and A-F both have low nibble 1..6, so adding 9 yields 10..15.
        if (is_dec) begin
            nibble = ch[3:0];
        end else if (is_lo || is_up) begin
            nibble = ch[3:0] + 4'd9;
        end
    end

endmodule

// File: rtl/str_to_num_param.sv
// Converts an ASCII byte stream into one NUM_W-bit integer per number token.
// The result is valid one cycle after the terminator is consumed.
// Input is stalled (s_rdy=0) only while a result waits for n_rdy.
module str_to_num_param
    import str_to_num_pkg::*;
#(
    parameter int NUM_W     = 32,
    parameter int SIGNED_EN = 1,
    parameter int HEX_EN    = 1,
    parameter int SATURATE  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       s_dtm,
    input  logic             s_vld,
    output logic             s_rdy,
    output logic [NUM_W-1:0] n_dtm,
    output logic             n_ovf,
    output logic             n_err,
    output logic             n_vld,
    input  logic             n_rdy
);

    localparam int ACC_W = NUM_W + 4;
    localparam logic [ACC_W-1:0] ONE   = ACC_W'(1);
    localparam logic [ACC_W-1:0] LIM_U = (ONE << NUM_W) - ONE;
    localparam logic [ACC_W-1:0] LIM_P = (ONE << (NUM_W - 1)) - ONE;
    localparam logic [ACC_W-1:0] LIM_N = ONE << (NUM_W - 1);

    state_t state;
    state_t state_nxt;

    logic [ACC_W-1:0] acc;
    logic             neg;
    logic             ovf;

    logic             is_dec;
    logic             is_hex;
    logic [3:0]       nib;
    logic             zero_hex;
    logic             is_minus;
    logic             is_x;

    logic [ACC_W-1:0] lim;
    logic [ACC_W-1:0] dec_upd;
    logic [ACC_W-1:0] hex_upd;
    logic [ACC_W-1:0] upd_raw;
    logic             upd_ovf;
    logic [ACC_W-1:0] acc_upd;
    logic [NUM_W-1:0] mag;
    logic [NUM_W-1:0] value;

    ascii_digit_decode u_dec (
        .ch     (s_dtm),
        .is_dec (is_dec),
        .is_hex (is_hex),
        .nibble (nib)
    );

    assign zero_hex = (HEX_EN != 0) && (s_dtm == CH_0);
    assign is_minus = (SIGNED_EN != 0) && (s_dtm == CH_MINUS);
    assign is_x     = (s_dtm == CH_LX) || (s_dtm == CH_UX);

    // The accumulator never holds more than NUM_W significant bits between
    // digits, so the 4 spare bits absorb one x10 or x16 step without loss.
    always_comb begin
        if (SIGNED_EN == 0)  lim = LIM_U;
        else if (neg)        lim = LIM_N;
        else                 lim = LIM_P;
        dec_upd = (acc << 3) + (acc << 1) + {{(ACC_W-4){1'b0}}, nib};
        hex_upd = {acc[ACC_W-5:0], nib};
        upd_raw = (state == HEX) ? hex_upd : dec_upd;
        upd_ovf = upd_raw > lim;
        acc_upd = upd_raw;
        if (upd_ovf) acc_upd = (SATURATE != 0) ? lim : (upd_raw & LIM_U);
        mag   = acc[NUM_W-1:0];
        value = neg ? -mag : mag;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (state == SEND) begin
            if (n_rdy) state_nxt = IDLE;
        end else if (s_vld) begin
            case (state)
                IDLE: begin
                    if (zero_hex)      state_nxt = LEAD0;
                    else if (is_dec)   state_nxt = DEC;
                    else if (is_minus) state_nxt = NEG;
                end
                NEG: begin
                    if (zero_hex)    state_nxt = LEAD0;
                    else if (is_dec) state_nxt = DEC;
                    else             state_nxt = IDLE;
                end
                LEAD0: begin
                    if (is_x)        state_nxt = HEXF;
                    else if (is_dec) state_nxt = DEC;
                    else             state_nxt = SEND;
                end
                DEC:     state_nxt = is_dec ? DEC : SEND;
                HEXF:    state_nxt = is_hex ? HEX : SEND;
                HEX:     state_nxt = is_hex ? HEX : SEND;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        s_rdy = (state != SEND);
        n_vld = (state == SEND);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc   <= '0;
            neg   <= 1'b0;
            ovf   <= 1'b0;
            n_dtm <= '0;
            n_ovf <= 1'b0;
            n_err <= 1'b0;
        end else begin
            if (state == SEND) begin
                if (n_rdy) begin
                    acc <= '0;
                    neg <= 1'b0;
                    ovf <= 1'b0;
                end
            end else if (s_vld) begin
                case (state)
                    IDLE, NEG: begin
                        if (is_dec)             acc <= {{(ACC_W-4){1'b0}}, nib};
                        else if (state == NEG)  neg <= 1'b0;
                        else if (is_minus)      neg <= 1'b1;
                    end
                    LEAD0: if (is_dec) acc <= {{(ACC_W-4){1'b0}}, nib};
                    HEXF:  if (is_hex) acc <= {{(ACC_W-4){1'b0}}, nib};
                    DEC, HEX: begin
                        if ((state == DEC) ? is_dec : is_hex) begin
                            acc <= acc_upd;
                            ovf <= ovf | upd_ovf;
                        end
                    end
                    default: ;
                endcase
            end
            // Result is captured on the terminator so it stays frozen through SEND.
            if ((state != SEND) && (state_nxt == SEND)) begin
                n_dtm <= (state == HEXF) ? '0 : value;
                n_ovf <= (state == HEXF) ? 1'b0 : ovf;
                n_err <= (state == HEXF);
            end
        end
    end

endmodule

// File: tb/tb_str_to_num_param.sv
// Bench for str_to_num_param: three parameterisations fed ASCII streams, with
// expected tokens queued before each stream and popped as each result is accepted.
module tb_str_to_num_param;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] s_dtm [3];
    logic [2:0] s_vld;
    logic [2:0] n_rdy;
    wire  [2:0] s_rdy;
    wire  [2:0] n_vld;
    wire  [2:0] n_ovf;
    wire  [2:0] n_err;
    wire [31:0] d0_dtm;
    wire  [7:0] d1_dtm;
    wire  [7:0] d2_dtm;

    always #5 clk = ~clk;

    str_to_num_param #(.NUM_W(32), .SIGNED_EN(1), .HEX_EN(1), .SATURATE(1)) u0 (
        .clk(clk), .rst(rst), .s_dtm(s_dtm[0]), .s_vld(s_vld[0]), .s_rdy(s_rdy[0]),
        .n_dtm(d0_dtm), .n_ovf(n_ovf[0]), .n_err(n_err[0]), .n_vld(n_vld[0]), .n_rdy(n_rdy[0]));

    str_to_num_param #(.NUM_W(8), .SIGNED_EN(1), .HEX_EN(1), .SATURATE(1)) u1 (
        .clk(clk), .rst(rst), .s_dtm(s_dtm[1]), .s_vld(s_vld[1]), .s_rdy(s_rdy[1]),
        .n_dtm(d1_dtm), .n_ovf(n_ovf[1]), .n_err(n_err[1]), .n_vld(n_vld[1]), .n_rdy(n_rdy[1]));

    str_to_num_param #(.NUM_W(8), .SIGNED_EN(0), .HEX_EN(1), .SATURATE(0)) u2 (
        .clk(clk), .rst(rst), .s_dtm(s_dtm[2]), .s_vld(s_vld[2]), .s_rdy(s_rdy[2]),
        .n_dtm(d2_dtm), .n_ovf(n_ovf[2]), .n_err(n_err[2]), .n_vld(n_vld[2]), .n_rdy(n_rdy[2]));

    typedef struct {
        int          dut;
        logic [31:0] dtm;
        logic        ovf;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    function automatic logic [31:0] obs_dtm(input int d);
        if (d == 0)      return d0_dtm;
        else if (d == 1) return {24'd0, d1_dtm};
        else             return {24'd0, d2_dtm};
    endfunction

    // Inputs change 1 time unit after posedge, so the negedge sees a settled
    // handshake that will complete on the following posedge.
    always @(negedge clk) begin
        if (!rst) begin
            for (int d = 0; d < 3; d++) begin
                if (n_vld[d] && n_rdy[d]) begin
                    exp_t e;
                    logic [31:0] od;
                    od = obs_dtm(d);
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_output dut%0d got n_dtm=%0h with nothing expected", d, od);
                    end else begin
                        e = sb.pop_front();
                        checks++;
                        if (e.dut != d || od !== e.dtm) begin
                            errors++;
                            $display("FAIL n_dtm dut%0d got %0h expected %0h (dut%0d)", d, od, e.dtm, e.dut);
                        end
                        checks++;
                        if (n_ovf[d] !== e.ovf) begin
                            errors++;
                            $display("FAIL n_ovf dut%0d got %b expected %b", d, n_ovf[d], e.ovf);
                        end
                        checks++;
                        if (n_err[d] !== e.err) begin
                            errors++;
                            $display("FAIL n_err dut%0d got %b expected %b", d, n_err[d], e.err);
                        end
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int d, input logic [31:0] v, input logic o, input logic e);
        exp_t x;
        x.dut = d;
        x.dtm = v;
        x.ovf = o;
        x.err = e;
        sb.push_back(x);
    endtask

    task automatic send_char(input int d, input logic [7:0] c);
        int n;
        n = 0;
        s_dtm[d] = c;
        s_vld[d] = 1'b1;
        while (s_rdy[d] !== 1'b1 && n < 200) begin
            step();
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL send_timeout dut%0d s_rdy stuck at %b, required 1", d, s_rdy[d]);
        end
        step();
        s_vld[d] = 1'b0;
    endtask

    task automatic send_str(input int d, input string s);
        for (int i = 0; i < s.len(); i++) send_char(d, s[i]);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            step();
            n++;
        end
        repeat (3) step();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_%s outstanding=%0d required 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        s_vld = 3'b000;
        n_rdy = 3'b111;
        for (int d = 0; d < 3; d++) s_dtm[d] = 8'h00;
        repeat (3) step();
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (n_vld[d] !== 1'b0) begin errors++; $display("FAIL reset_n_vld dut%0d got %b required 0", d, n_vld[d]); end
            checks++;
            if (s_rdy[d] !== 1'b1) begin errors++; $display("FAIL reset_s_rdy dut%0d got %b required 1", d, s_rdy[d]); end
            checks++;
            if (obs_dtm(d) !== 32'd0) begin errors++; $display("FAIL reset_n_dtm dut%0d got %0h required 0", d, obs_dtm(d)); end
            checks++;
            if (n_ovf[d] !== 1'b0 || n_err[d] !== 1'b0) begin
                errors++;
                $display("FAIL reset_flags dut%0d got ovf=%b err=%b required 0 0", d, n_ovf[d], n_err[d]);
            end
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic();
        push(0, 32'd123, 1'b0, 1'b0);
        send_str(0, "123");
        checks++;
        if (n_vld[0] !== 1'b0) begin errors++; $display("FAIL early_n_vld got %b required 0", n_vld[0]); end
        send_char(0, 8'h20);
        checks++;
        if (n_vld[0] !== 1'b1) begin errors++; $display("FAIL latency_n_vld got %b required 1", n_vld[0]); end
        drain("basic");
    endtask

    task automatic test_hold();
        push(0, 32'hFFFF_FFD6, 1'b0, 1'b0);
        push(0, 32'd31, 1'b0, 1'b0);
        n_rdy[0] = 1'b0;
        send_str(0, "-42,");
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (n_vld[0] !== 1'b1) begin errors++; $display("FAIL hold_n_vld cycle%0d got %b required 1", i, n_vld[0]); end
            checks++;
            if (s_rdy[0] !== 1'b0) begin errors++; $display("FAIL hold_s_rdy cycle%0d got %b required 0", i, s_rdy[0]); end
            checks++;
            if (d0_dtm !== 32'hFFFF_FFD6) begin errors++; $display("FAIL hold_n_dtm cycle%0d got %0h required ffffffd6", i, d0_dtm); end
            step();
        end
        n_rdy[0] = 1'b1;
        send_str(0, "0x1F;");
        drain("hold");
    endtask

    task automatic test_tokens();
        push(0, 32'd0, 1'b0, 1'b1);
        push(0, 32'd0, 1'b0, 1'b0);
        push(0, 32'd7, 1'b0, 1'b0);
        send_str(0, "0x; - 0 ab7\n");
        push(0, 32'd0, 1'b0, 1'b0);
        push(0, 32'd7, 1'b0, 1'b0);
        push(0, 32'hAB, 1'b0, 1'b0);
        push(0, 32'hFFFF_FFE1, 1'b0, 1'b0);
        push(0, 32'h7FFF_FFFF, 1'b1, 1'b0);
        send_str(0, "-0 007 0XaB -0x1F 4294967296 ");
        drain("tokens");
    endtask

    task automatic test_saturate();
        push(1, 32'd127, 1'b1, 1'b0);
        push(1, 32'h80, 1'b1, 1'b0);
        push(1, 32'h80, 1'b0, 1'b0);
        push(1, 32'd127, 1'b0, 1'b0);
        push(1, 32'd127, 1'b1, 1'b0);
        push(1, 32'h80, 1'b0, 1'b0);
        push(1, 32'h80, 1'b1, 1'b0);
        send_str(1, "200 -129 -128 0x7F 0xFF -0x80 -9999 ");
        drain("saturate");
    endtask

    task automatic test_wrap();
        push(2, 32'd44, 1'b1, 1'b0);
        push(2, 32'd255, 1'b0, 1'b0);
        push(2, 32'd0, 1'b1, 1'b0);
        push(2, 32'd5, 1'b0, 1'b0);
        push(2, 32'hFF, 1'b1, 1'b0);
        send_str(2, "300 255 256 -5 0x1FF ");
        drain("wrap");
    endtask

    task automatic test_back_to_back();
        push(0, 32'd1, 1'b0, 1'b0);
        push(0, 32'd2, 1'b0, 1'b0);
        push(0, 32'd3, 1'b0, 1'b0);
        send_str(0, "1 2 3\n");
        drain("back_to_back");
    endtask

    task automatic test_reset_abort();
        n_rdy[0] = 1'b0;
        send_str(0, "9 ");
        rst = 1'b1;
        step();
        checks++;
        if (n_vld[0] !== 1'b0) begin errors++; $display("FAIL abort_send_n_vld got %b required 0", n_vld[0]); end
        checks++;
        if (s_rdy[0] !== 1'b1) begin errors++; $display("FAIL abort_send_s_rdy got %b required 1", s_rdy[0]); end
        checks++;
        if (d0_dtm !== 32'd0) begin errors++; $display("FAIL abort_send_n_dtm got %0h required 0", d0_dtm); end
        rst = 1'b0;
        n_rdy[0] = 1'b1;
        step();
        send_str(0, "12");
        rst = 1'b1;
        step();
        rst = 1'b0;
        push(0, 32'd5, 1'b0, 1'b0);
        send_str(0, "5 ");
        drain("reset_abort");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold();
        test_tokens();
        test_saturate();
        test_wrap();
        test_back_to_back();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/str_to_num_param.md
Name: str_to_num_param

Overview:
Parametrised successor to the ASCII-to-integer stream converter. Consumes a byte stream of ASCII characters and emits one integer per number token found in it.
- Adds configurable output width.
- Adds an optional leading '-' sign and an optional "0x"/"0X" hex prefix.
- Adds overflow detection with optional saturation, and a malformed-token error flag.
Sits between a UART/byte FIFO and command-parsing logic.

Parameters:
NUM_W, 32, output integer width in bits (legal range 8..64)
SIGNED_EN, 1, 1 = accept leading '-' and emit two's-complement result; 0 = '-' treated as non-digit
HEX_EN, 1, 1 = "0x"/"0X" prefix selects hex digits 0-9, a-f, A-F; 0 = decimal only
SATURATE, 1, 1 = on overflow emit clamped limit; 0 = emit low NUM_W bits of wrapped result

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
s_dtm  in  8  input ASCII character
s_vld  in  1  input valid
s_rdy  out  1  input ready
n_dtm  out  NUM_W  converted number
n_ovf  out  1  number exceeded representable range (qualified by n_vld)
n_err  out  1  malformed token, n_dtm forced 0 (qualified by n_vld)
n_vld  out  1  output valid
n_rdy  in  1  output ready

Behaviour:
- One clock domain `clk`; `rst` is synchronous and active-high.
- Reset values: state IDLE, n_vld=0, s_rdy=1, n_dtm=0, n_ovf=0, n_err=0, accumulator=0, neg=0.
- Reset mid-token or mid-SEND drops the partial or pending number; no output is emitted.
- Input handshake: a character is consumed when s_vld&&s_rdy.
- s_rdy=1 in every state except SEND. s_rdy must not depend combinationally on s_vld.
- Output handshake: n_vld=1 only in SEND. n_dtm/n_ovf/n_err are held stable while n_vld&&!n_rdy.
- Leaving SEND: on n_vld&&n_rdy, go to IDLE the next cycle. Minimum gap between tokens is therefore 1 cycle after the terminator.
- Latency: n_vld rises the cycle after the terminating character is consumed.
- The terminator character is consumed and discarded.
- States and transitions, taken only on a consumed character:
  - IDLE: '0' with HEX_EN -> LEAD0. Other digit -> DEC (acc=digit). '-' with SIGNED_EN -> NEG (neg=1). Anything else -> stay.
  - NEG: '0' with HEX_EN -> LEAD0. Digit -> DEC. Non-digit -> IDLE silently, no output.
  - LEAD0: 'x'/'X' -> HEXF. Digit -> DEC (acc=digit). Non-digit -> SEND with value 0.
  - DEC: digit -> acc=acc*10+d. Non-digit -> SEND.
  - HEXF: hex digit -> HEX (acc=h). Non-hex -> SEND with n_err=1, n_dtm=0.
  - HEX: hex digit -> acc=(acc<<4)|h. Non-hex -> SEND.
  - SEND: see output handshake above.
- Accumulator is NUM_W+4 bits.
- Magnitude limit LIM:
  - SIGNED_EN=0: 2^NUM_W-1.
  - SIGNED_EN=1, neg=0: 2^(NUM_W-1)-1.
  - SIGNED_EN=1, neg=1: 2^(NUM_W-1).
- Overflow:
  - If an update result exceeds LIM, set sticky ovf.
  - With SATURATE=1, acc is pinned to LIM for the rest of the token and further digits are still consumed.
  - With SATURATE=0, acc keeps its low NUM_W bits.
- Output value: n_dtm = neg ? -acc[NUM_W-1:0] : acc[NUM_W-1:0]. The sign applies to hex magnitudes too.
- "-0" emits 0 with n_ovf=0.
- Leading zeros in decimal ("007") are legal and give 7.

Decomposition:
- Package str_to_num_pkg holds:
  - state enum constants (IDLE, NEG, LEAD0, DEC, HEXF, HEX, SEND), 3-bit;
  - ASCII constants for '0', '9', 'a', 'f', 'A', 'F', 'x', 'X', '-'.
- Sub-module ascii_digit_decode is combinational: s_dtm -> is_dec, is_hex, nibble[3:0]. It is reused by future parsers.
- The FSM, accumulator and limit compare stay in str_to_num_param.

Test Plan:
- NUM_W=32, stream "123 " with n_rdy=1 -> one output n_dtm=123, n_ovf=0, n_err=0; n_vld rises 1 cycle after ' ' is consumed.
- Stream "-42,0x1F;" -> n_dtm=0xFFFFFFD6 (-42), then n_dtm=31. Holding n_rdy=0 for 5 cycles keeps n_vld=1 with values stable, s_rdy=0.
- NUM_W=8, SIGNED_EN=1, SATURATE=1, stream "200 -129 -128 " -> 127 with ovf=1; 0x80 with ovf=1; 0x80 with ovf=0.
- NUM_W=8, SATURATE=0, SIGNED_EN=0, stream "300 " -> n_dtm=44, n_ovf=1.
- Stream "0x; - 0 ab7\n" -> 0 with n_err=1; lone '-' gives no output; 0 with n_err=0; 7.
- Assert rst after "12" is consumed, then send "5 " -> single output 5. No output for the aborted token.
